m_ser9_rx: RTL
==============

// Module: m_ser9_rx
// PURPOSE
//  Serial 9-bit word receiver. Reassembles LSB-first asynchronous frames
//  (start, 9 data, stop) from RXD and presents them as a parallel word.
//  Provides valid/ready handoff to the host-side register file.
//  Sits opposite the 9-bit word reduction/decode logic: rebuilds the 9 bits
//  that the decode terms consume, and flags the all-ones word directly.
// PARAMETERS
//  OSR    16  ticks per bit period; even, >=4
//  WIDTH  9   data bits per frame; fixed at 9 in this build
// PORTS
//  CLOCK     in   1      system clock; all state on rising edge
//  RESETL    in   1      synchronous reset, active low
//  TICK      in   1      one-cycle enable at OSR x bit rate
//  RXD       in   1      serial line; asynchronous, idles high
//  DREADY    in   1      host accepts DOUT when DVALID & DREADY
//  DOUT      out  WIDTH  received word, LSB = first data bit
//  DVALID    out  1      DOUT holds an unconsumed word
//  ALLONES   out  1      DVALID & (DOUT == all ones)
//  FERR      out  1      one-cycle pulse: stop bit sampled low
//  OVERRUN   out  1      one-cycle pulse: new word dropped, holding reg full
//  BUSY      out  1      state != IDLE
// BEHAVIOUR
//  Reset (RESETL=0 at edge): state IDLE, DOUT=0, DVALID=0, FERR=0,
//   OVERRUN=0, BUSY=0, sync flops=1, tick count=0, bit index=0.
//   Reset mid-frame abandons the frame; partial bits are never delivered.
//  RXD passes a 2-flop synchronizer; "line" below means the synced value.
//  Tick counter and sampling advance only on cycles with TICK=1.
//  States:
//   IDLE:  line=0 on a TICK cycle -> START, count=0.
//   START: at count=OSR/2-1, sample line. 1 -> IDLE (glitch rejected,
//          no flag). 0 -> DATA, count=0, bit=0.
//   DATA:  at count=OSR-1, shift line into bit[bit], count=0, bit++;
//          after bit WIDTH-1 sampled -> STOP.
//   STOP:  at count=OSR-1, sample line.
//          1 -> deliver word, -> IDLE.
//          0 -> FERR pulse, word discarded, -> BREAK.
//   BREAK: wait for line=1 on a TICK cycle -> IDLE (no new start while low).
//  Samples land mid-bit: the START sample is half a bit in; each later
//   sample is a whole bit after the previous one.
//  Delivery, same cycle as the stop sample:
//   DVALID=0, or DREADY=1: DOUT <= word, DVALID <= 1 (next cycle).
//   DVALID=1 and DREADY=0: DOUT unchanged, OVERRUN pulses 1 cycle.
//  Consume: DVALID & DREADY with no delivery that cycle -> DVALID <= 0.
//   If delivery and consume coincide, the new word loads and DVALID stays 1.
//  DOUT stable whenever DVALID=1 and not being replaced.
//  ALLONES is combinational from registered DOUT/DVALID; it adds no latency.
//  Latency: DVALID rises 1 CLOCK after the TICK cycle that samples the stop
//   bit, which is ~(10.5 x OSR) ticks after the start edge, plus 2 sync cycles.
//  FERR and OVERRUN never both assert in one cycle.
// TESTING
//  T1 frame 9'h0A5, OSR=16, DREADY=1 -> DVALID 1 cycle, DOUT=9'h0A5,
//     ALLONES=0, FERR=0.
//  T2 frame 9'h1FF, DREADY=0 -> DVALID=1 held, DOUT=9'h1FF, ALLONES=1
//     until DREADY pulses; then DVALID=0, ALLONES=0.
//  T3 RXD low for 4 ticks only -> START then IDLE; no DVALID, no FERR.
//  T4 frame 9'h055 with stop bit=0, line low 3 more bit times -> FERR one
//     cycle, DVALID stays 0, no new frame until RXD high; next frame 9'h003
//     is received correctly.
//  T5 frames 9'h101 then 9'h0FE back to back, DREADY=0 -> DOUT=9'h101,
//     OVERRUN one cycle at the second stop; assert DREADY on the delivery
//     cycle instead -> DOUT=9'h0FE, DVALID stays 1.
//  T6 RESETL=0 for 1 cycle during data bit 4 -> all outputs 0, BUSY=0;
//     the following full frame 9'h12C is received intact.

Source files
------------

// File: rtl/m_ser9_rx.sv
// Serial 9-bit word receiver: rebuilds LSB-first start/9-data/stop frames from RXD
// and hands each word to the host through a one-deep valid/ready holding register.
module m_ser9_rx #(
    parameter int OSR   = 16,
    parameter int WIDTH = 9
) (
    input  logic             CLOCK,
    input  logic             RESETL,
    input  logic             TICK,
    input  logic             RXD,
    input  logic             DREADY,
    output logic [WIDTH-1:0] DOUT,
    output logic             DVALID,
    output logic             ALLONES,
    output logic             FERR,
    output logic             OVERRUN,
    output logic             BUSY
);

    localparam int CW = $clog2(OSR);
    localparam int BW = $clog2(WIDTH + 1);

    localparam logic [CW-1:0] HALF_LAST = CW'(OSR / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(OSR - 1);
    localparam logic [BW-1:0] IDX_LAST  = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t           state;
    logic             rxd_p0;
    logic             rxd_p1;
    logic [CW-1:0]    cnt;
    logic [BW-1:0]    bit_idx;
    logic [WIDTH-1:0] shreg;

    logic stop_tick;
    logic deliver;
    logic can_load;

    always_comb begin
        stop_tick = (state == S_STOP) && TICK && (cnt == BIT_LAST);
        deliver   = stop_tick && rxd_p1;
        can_load  = !DVALID || DREADY;
    end

    // A good stop bit and an emptying holding register in the same cycle
    // replace the word rather than dropping DVALID for a cycle.
    always_ff @(posedge CLOCK) begin
        if (!RESETL) begin
            state   <= S_IDLE;
            rxd_p0  <= 1'b1;
            rxd_p1  <= 1'b1;
            cnt     <= '0;
            bit_idx <= '0;
            DOUT    <= '0;
            DVALID  <= 1'b0;
            FERR    <= 1'b0;
            OVERRUN <= 1'b0;
        end else begin
            // stage p0 -> p1: two-flop synchronizer on the asynchronous line
            rxd_p0  <= RXD;
            rxd_p1  <= rxd_p0;
            FERR    <= 1'b0;
            OVERRUN <= 1'b0;

            if (deliver) begin
                if (can_load) begin
                    DOUT   <= shreg;
                    DVALID <= 1'b1;
                end else begin
                    OVERRUN <= 1'b1;
                end
            end else if (DVALID && DREADY) begin
                DVALID <= 1'b0;
            end

            if (TICK) begin
                case (state)
                    S_IDLE: begin
                        if (!rxd_p1) begin
                            state <= S_START;
                            cnt   <= '0;
                        end
                    end
                    S_START: begin
                        if (cnt == HALF_LAST) begin
                            cnt     <= '0;
                            bit_idx <= '0;
                            state   <= rxd_p1 ? S_IDLE : S_DATA;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (cnt == BIT_LAST) begin
                            cnt     <= '0;
                            shreg   <= {rxd_p1, shreg[WIDTH-1:1]};
                            bit_idx <= bit_idx + 1'b1;
                            if (bit_idx == IDX_LAST) begin
                                state <= S_STOP;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_STOP: begin
                        if (cnt == BIT_LAST) begin
                            cnt <= '0;
                            if (rxd_p1) begin
                                state <= S_IDLE;
                            end else begin
                                FERR  <= 1'b1;
                                state <= S_BREAK;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_BREAK: begin
                        if (rxd_p1) begin
                            state <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign ALLONES = DVALID && (DOUT == {WIDTH{1'b1}});
    assign BUSY    = (state != S_IDLE);

endmodule
